// File: rtl/atomic_bus_arbiter.sv
// atomic_bus_arbiter
//   Serialises N_IDS requesters onto one memory port, one transaction in
//   flight. It supports plain load/store plus LR/SC against an external
//   reservation table.
//   FSM: IDLE -> (CHECK for SC) -> MEM -> RESP -> IDLE.
//
// Configuration macro:
//   ATOMIC_ARB_RR_EN - round-robin arbitration. When it is undefined,
//                      arbitration is fixed priority and the lowest id wins.
//
// Ports:
//   i_clk, i_rst          clock and synchronous active-high reset
//   i_req/i_we/i_lr/i_sc  per-requester request and kind qualifiers
//   i_addr, i_wdata       packed per-requester address and write data
//   o_ack, o_rdata        one-cycle completion pulse and shared response data
//   o_mem_*, i_mem_*      memory port; en is held until i_mem_ack
//   o_tbl_*, i_tbl_gnt    reservation table (check / set / invalidate-on-write)
`ifndef XLEN
`define XLEN 32
`endif

module atomic_bus_arbiter #(
    parameter int N_IDS      = 2,
    parameter int ADDR_WIDTH = `XLEN
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [N_IDS-1:0]            i_req,
    input  logic [N_IDS-1:0]            i_we,
    input  logic [N_IDS-1:0]            i_lr,
    input  logic [N_IDS-1:0]            i_sc,
    input  logic [N_IDS*ADDR_WIDTH-1:0] i_addr,
    input  logic [N_IDS*32-1:0]         i_wdata,
    output logic [N_IDS-1:0]            o_ack,
    output logic [31:0]                 o_rdata,
    output logic                        o_mem_en,
    output logic                        o_mem_we,
    output logic [ADDR_WIDTH-1:0]       o_mem_addr,
    output logic [31:0]                 o_mem_wdata,
    input  logic [31:0]                 i_mem_rdata,
    input  logic                        i_mem_ack,
    output logic                        o_tbl_wr_en,
    output logic                        o_tbl_set_res,
    output logic                        o_tbl_check_res,
    output logic [$clog2(N_IDS)-1:0]    o_tbl_id,
    output logic [ADDR_WIDTH-1:0]       o_tbl_addr,
    input  logic                        i_tbl_gnt
);
    localparam int IDW = $clog2(N_IDS);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_MEM, S_RESP} state_t;
    typedef enum logic [1:0] {K_LD, K_ST, K_LR, K_SC} kind_t;

    state_t                r_state, w_state_nxt;
    kind_t                 r_kind, w_gnt_kind;
    logic [IDW-1:0]        r_id, w_gnt_id;
    logic                  w_gnt_vld;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata, r_rdata;
    logic                  w_is_write;

    // ---------------- arbitration ----------------
`ifdef ATOMIC_ARB_RR_EN
    logic [IDW-1:0] r_ptr;
    logic [IDW:0]   w_idx;  // one spare bit holds ptr+i before the wrap

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = '0;
        w_idx     = '0;
        for (int i = 1; i <= N_IDS; i++) begin
            w_idx = {1'b0, r_ptr} + (IDW+1)'(i);
            if (w_idx >= (IDW+1)'(N_IDS))
                w_idx = w_idx - (IDW+1)'(N_IDS);
            if (!w_gnt_vld && i_req[w_idx[IDW-1:0]]) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = w_idx[IDW-1:0];
            end
        end
    end

    // The pointer moves only on a grant. Reset points it at the last id, so the search begins at id 0.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_ptr <= IDW'(N_IDS-1);
        else if (r_state == S_IDLE && w_gnt_vld)
            r_ptr <= w_gnt_id;
    end
`else
    // The scan runs from high to low, so the lowest requesting id is the last to win.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = '0;
        for (int i = N_IDS-1; i >= 0; i--) begin
            if (i_req[i]) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = IDW'(i);
            end
        end
    end
`endif

    always_comb begin
        if (i_sc[w_gnt_id])      w_gnt_kind = K_SC;
        else if (i_lr[w_gnt_id]) w_gnt_kind = K_LR;
        else if (i_we[w_gnt_id]) w_gnt_kind = K_ST;
        else                     w_gnt_kind = K_LD;
    end

    // An SC only reaches MEM after the table has granted it, so it always writes there.
    assign w_is_write = (r_kind == K_ST) || (r_kind == K_SC);

    // ---------------- FSM next state / outputs ----------------
    // Strobes and the ack are masked by i_rst. A transaction aborted by reset
    // therefore leaves no trace on the table or on the requesters.
    always_comb begin
        w_state_nxt     = r_state;
        o_ack           = '0;
        o_mem_en        = 1'b0;
        o_mem_we        = 1'b0;
        o_mem_addr      = '0;
        o_mem_wdata     = '0;
        o_tbl_wr_en     = 1'b0;
        o_tbl_set_res   = 1'b0;
        o_tbl_check_res = 1'b0;
        o_tbl_id        = '0;
        o_tbl_addr      = '0;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_vld)
                    w_state_nxt = (w_gnt_kind == K_SC) ? S_CHECK : S_MEM;
            end
            S_CHECK: begin
                o_tbl_check_res = !i_rst;
                o_tbl_id        = r_id;
                o_tbl_addr      = r_addr;
                w_state_nxt     = i_tbl_gnt ? S_MEM : S_RESP;
            end
            S_MEM: begin
                o_mem_en    = 1'b1;
                o_mem_we    = w_is_write;
                o_mem_addr  = r_addr;
                o_mem_wdata = r_wdata;
                if (i_mem_ack) begin
                    w_state_nxt   = S_RESP;
                    o_tbl_wr_en   = w_is_write && !i_rst;
                    o_tbl_set_res = (r_kind == K_LR) && !i_rst;
                    o_tbl_id      = r_id;
                    o_tbl_addr    = r_addr;
                end
            end
            S_RESP: begin
                o_ack[r_id] = !i_rst;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- state and latched transaction ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_kind  <= K_LD;
            r_id    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_vld) begin
                        r_id    <= w_gnt_id;
                        r_kind  <= w_gnt_kind;
                        r_addr  <= i_addr[w_gnt_id*ADDR_WIDTH +: ADDR_WIDTH];
                        r_wdata <= i_wdata[w_gnt_id*32 +: 32];
                    end
                end
                S_CHECK: begin
                    if (!i_tbl_gnt)
                        r_rdata <= 32'd1;  // SC failure code
                end
                S_MEM: begin
                    if (i_mem_ack)
                        r_rdata <= (r_kind == K_LD || r_kind == K_LR) ? i_mem_rdata : 32'd0;
                end
                default: ;
            endcase
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: tb/tb_atomic_bus_arbiter.sv
module tb_atomic_bus_arbiter;
    localparam int N  = 2;
    localparam int AW = 32;

    typedef enum int {LD, ST, LR, SC} kind_e;
    typedef struct {
        int          id;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic [N-1:0]      req = '0, we = '0, lr = '0, sc = '0;
    logic [N*AW-1:0]   addr = '0;
    logic [N*32-1:0]   wdata = '0;
    logic [N-1:0]      ack;
    logic [31:0]       rdata;
    logic              mem_en, mem_we;
    logic [AW-1:0]     mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = '0;
    logic              mem_ack = 1'b0;
    logic              tbl_wr_en, tbl_set_res, tbl_check_res;
    logic [0:0]        tbl_id;
    logic [AW-1:0]     tbl_addr;
    logic              tbl_gnt;

    atomic_bus_arbiter #(.N_IDS(N), .ADDR_WIDTH(AW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req(req), .i_we(we), .i_lr(lr), .i_sc(sc),
        .i_addr(addr), .i_wdata(wdata),
        .o_ack(ack), .o_rdata(rdata),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack),
        .o_tbl_wr_en(tbl_wr_en), .o_tbl_set_res(tbl_set_res),
        .o_tbl_check_res(tbl_check_res), .o_tbl_id(tbl_id),
        .o_tbl_addr(tbl_addr), .i_tbl_gnt(tbl_gnt)
    );

    int total = 0, bad = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [N-1:0] mon_oh;

    // event counters (monitor-owned), snapshots (main-owned)
    int cnt_ack = 0, cnt_wr = 0, cnt_set = 0, cnt_chk = 0, cnt_mem = 0, cnt_memwe = 0;
    int s_ack, s_wr, s_set, s_chk, s_mem, s_memwe;
    int rearm[N];

    // reservation table model
    logic          res_vld[N];
    logic [AW-1:0] res_addr[N];
    assign tbl_gnt = tbl_check_res && res_vld[tbl_id] && (res_addr[tbl_id] == tbl_addr);

    // memory model: ack in the second MEM cycle; unwritten locations read CAFE_xxxx
    logic [31:0] mem[logic [AW-1:0]];
    int   mem_cnt = 0;
    logic force_ack = 1'b0;

    function automatic logic [31:0] mem_rd(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'hCAFE_0000 | {16'h0, a[15:0]};
    endfunction

    initial begin
        forever begin
            @(posedge clk); #2;
            if (mem_en) mem_cnt++; else mem_cnt = 0;
            mem_ack = (mem_cnt == 2) || force_ack;
            if (mem_cnt == 2 && mem_we) mem[mem_addr] = mem_wdata;
            mem_rdata = mem_rd(mem_addr);
        end
    end

    // monitor / scoreboard
    initial begin
        for (int k = 0; k < N; k++) begin res_vld[k] = 1'b0; res_addr[k] = '0; end
        forever begin
            @(negedge clk);
            if (tbl_wr_en) begin
                cnt_wr++;
                for (int k = 0; k < N; k++)
                    if (res_vld[k] && res_addr[k] == tbl_addr) res_vld[k] = 1'b0;
            end
            if (tbl_set_res) begin
                cnt_set++;
                res_vld[tbl_id]  = 1'b1;
                res_addr[tbl_id] = tbl_addr;
            end
            if (tbl_check_res) cnt_chk++;
            if (mem_en) cnt_mem++;
            if (mem_en && mem_we) cnt_memwe++;
            if (ack != '0) begin
                cnt_ack++;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL ack_unexpected: got ack=%b rdata=%h, want no ack", ack, rdata);
                end else begin
                    mon_e  = sb.pop_front();
                    mon_oh = '0;
                    mon_oh[mon_e.id] = 1'b1;
                    if (ack !== mon_oh || rdata !== mon_e.rdata) begin
                        bad++;
                        $display("FAIL ack_resp: got ack=%b rdata=%h, want ack=%b rdata=%h",
                                 ack, rdata, mon_oh, mon_e.rdata);
                    end
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, expv);
        end
    endtask

    task automatic expect_resp(input int id, input logic [31:0] d);
        exp_t e;
        e.id = id;
        e.rdata = d;
        sb.push_back(e);
    endtask

    task automatic issue(input int k, input kind_e kd, input logic [AW-1:0] a, input logic [31:0] d);
        we[k] = (kd == ST);
        lr[k] = (kd == LR);
        sc[k] = (kd == SC);
        addr[k*AW +: AW]  = a;
        wdata[k*32 +: 32] = d;
        req[k] = 1'b1;
    endtask

    // Requester behaviour: drop the request after its ack, unless it is re-armed.
    task automatic serve(input int n_acks, input int budget, input string nm);
        int got = 0;
        int cyc = 0;
        logic [N-1:0] a_s;
        while (got < n_acks && cyc < budget) begin
            @(negedge clk);
            a_s = ack;
            @(posedge clk); #1;
            for (int k = 0; k < N; k++) begin
                if (a_s[k]) begin
                    got++;
                    if (rearm[k] > 0) rearm[k]--;
                    else req[k] = 1'b0;
                end
            end
            cyc++;
        end
        check({nm, "_acks"}, got, n_acks);
    endtask

    task automatic snap();
        s_ack = cnt_ack; s_wr = cnt_wr; s_set = cnt_set;
        s_chk = cnt_chk; s_mem = cnt_mem; s_memwe = cnt_memwe;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rearm[0] = 0; rearm[1] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ack",    ack, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_rdata",  rdata, 0);
        check("rst_tbl",    {tbl_wr_en, tbl_set_res, tbl_check_res}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // both loads at once: id0 first, then id1
        snap();
        expect_resp(0, 32'hCAFE_0040);
        expect_resp(1, 32'hCAFE_0080);
        issue(0, LD, 32'h40, 0);
        issue(1, LD, 32'h80, 0);
        serve(2, 40, "dual_load");
        check("dual_load_ackcnt", cnt_ack - s_ack, 2);

        // LR then SC success
        snap();
        expect_resp(0, 32'hCAFE_0100);
        issue(0, LR, 32'h100, 0);
        serve(1, 40, "lr0");
        check("lr0_set_res", cnt_set - s_set, 1);
        snap();
        expect_resp(0, 32'h0);
        issue(0, SC, 32'h100, 32'h1234_5678);
        serve(1, 40, "sc_ok");
        check("sc_ok_wr_en", cnt_wr - s_wr, 1);
        check("sc_ok_chk",   cnt_chk - s_chk, 1);
        check("sc_ok_memwe", cnt_memwe - s_memwe, 2);
        expect_resp(1, 32'h1234_5678);
        issue(1, LD, 32'h100, 0);
        serve(1, 40, "rd_after_sc");

        // LR, another id stores to the same address, SC fails
        expect_resp(0, 32'h1234_5678);
        issue(0, LR, 32'h100, 0);
        serve(1, 40, "lr1");
        expect_resp(1, 32'h0);
        issue(1, ST, 32'h100, 32'hDEAD_BEEF);
        serve(1, 40, "st1");
        snap();
        expect_resp(0, 32'h1);
        issue(0, SC, 32'h100, 32'h5555_5555);
        serve(1, 40, "sc_fail");
        check("sc_fail_mem",   cnt_mem - s_mem, 0);
        check("sc_fail_wr_en", cnt_wr - s_wr, 0);
        check("sc_fail_chk",   cnt_chk - s_chk, 1);
        check("sc_fail_ackcnt", cnt_ack - s_ack, 1);
        expect_resp(0, 32'hDEAD_BEEF);
        issue(0, LD, 32'h100, 0);
        serve(1, 40, "rd_after_fail");

        // continuous requests from both ids, arbitration order
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        rearm[0] = 2; rearm[1] = 2;
`ifdef ATOMIC_ARB_RR_EN
        for (int i = 0; i < 3; i++) begin
            expect_resp(0, 32'hCAFE_0040);
            expect_resp(1, 32'hCAFE_0080);
        end
`else
        for (int i = 0; i < 3; i++) expect_resp(0, 32'hCAFE_0040);
        for (int i = 0; i < 3; i++) expect_resp(1, 32'hCAFE_0080);
`endif
        issue(0, LD, 32'h40, 0);
        issue(1, LD, 32'h80, 0);
        serve(6, 100, "continuous");

        // reset during MEM with a late memory ack
        snap();
        issue(0, ST, 32'h300, 32'hA5A5_A5A5);
        @(posedge clk); #1;
        check("abort_in_mem", mem_en, 1);
        rst = 1'b1;
        req = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        force_ack = 1'b1;
        @(negedge clk);
        check("abort_mem_en", mem_en, 0);
        check("abort_wr_en",  tbl_wr_en, 0);
        check("abort_rdata",  rdata, 0);
        @(posedge clk); #1;
        force_ack = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_ackcnt", cnt_ack - s_ack, 0);
        check("abort_wrcnt",  cnt_wr - s_wr, 0);
        check("abort_idle",   mem_en, 0);
        expect_resp(0, 32'hCAFE_0300);
        issue(0, LD, 32'h300, 0);
        serve(1, 40, "rd_after_abort");

        repeat (2) @(posedge clk);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/atomic_bus_arbiter.md
ATOMIC_BUS_ARBITER -- requirements
Module: atomic_bus_arbiter

Interface
REQ-001 SHALL have parameter N_IDS, default 2, number of requesters (legal range 2..16).
REQ-002 SHALL have parameter ADDR_WIDTH, default `XLEN, address width.
REQ-003 SHALL have one clock; reset is synchronous and active-high: i_clk  in  1  rising-edge clock.
REQ-004 SHALL have i_rst  in  1  synchronous active-high reset.
REQ-005 SHALL have i_req  in  N_IDS  per-requester request, held until its o_ack.
REQ-006 SHALL have i_we / i_lr / i_sc  in  N_IDS each  store / load-reserved / store-conditional qualifiers (at most one set per requester).
REQ-007 SHALL have i_addr  in  N_IDS*ADDR_WIDTH  and i_wdata  in  N_IDS*32  packed, requester k at slice k.
REQ-008 SHALL have o_ack  out  N_IDS  one-cycle completion pulse; o_rdata  out  32  shared response data.
REQ-009 SHALL have o_mem_en, o_mem_we  out  1;  o_mem_addr  out  ADDR_WIDTH;  o_mem_wdata  out  32;  i_mem_rdata  in  32;  i_mem_ack  in  1.
REQ-010 SHALL have reservation-table port: o_tbl_wr_en, o_tbl_set_res, o_tbl_check_res  out  1;  o_tbl_id  out  $clog2(N_IDS);  o_tbl_addr  out  ADDR_WIDTH;  i_tbl_gnt  in  1 (combinational from table).

Function
REQ-011 SHALL implement FSM IDLE -> CHECK -> MEM -> RESP -> IDLE, one transaction in flight.
REQ-012 IDLE: SHALL grant one pending requester, latch id/addr/wdata/kind, go CHECK if SC else MEM; stay IDLE if no i_req.
REQ-013 Arbitration SHALL be round-robin: search starts at last granted id +1, wraps N_IDS-1 -> 0; pointer updates on grant only.
REQ-014 CHECK (one cycle): SHALL assert o_tbl_check_res with o_tbl_id/o_tbl_addr; i_tbl_gnt=1 -> MEM as write; 0 -> RESP with failure.
REQ-015 MEM: SHALL hold o_mem_en=1 with o_mem_we=1 for store/successful SC, 0 for load/LR, until i_mem_ack; ack not expected before second MEM cycle, sampled every MEM cycle.
REQ-016 On i_mem_ack for store/successful SC SHALL pulse o_tbl_wr_en with latched address (invalidates all matching reservations).
REQ-017 On i_mem_ack for LR SHALL pulse o_tbl_set_res with latched id/address.
REQ-018 RESP: SHALL pulse o_ack[id] for exactly one cycle; o_rdata = captured i_mem_rdata for load/LR, 0 for store, 0 for SC success, 1 for SC failure.
REQ-019 A requester SHALL not be re-granted in the cycle after its o_ack (IDLE intervenes).
REQ-020 All o_tbl_* strobes and o_mem_en SHALL be 0 outside their states; at most one o_tbl_* strobe per cycle.
REQ-021 Failed SC SHALL issue no memory access and no o_tbl_wr_en.
REQ-022 Request changes while not granted SHALL have no effect; latched fields SHALL not change mid-transaction.

Reset
REQ-023 i_rst=1 SHALL force IDLE, RR pointer to N_IDS-1 (id 0 first), all outputs 0, o_rdata 0, next cycle.
REQ-024 Reset mid-transaction SHALL abort without o_ack and without table strobes; pending memory ack is ignored.

Configuration
REQ-025 With ATOMIC_ARB_RR_EN defined, arbitration SHALL be round-robin per REQ-013.
REQ-026 Without ATOMIC_ARB_RR_EN, arbitration SHALL be fixed priority, lowest id wins; pointer logic absent; all else unchanged.

Verification
REQ-027 Reset, i_req=2'b11 both loads, mem ack after 2 cycles -> id0 acked first, then id1; o_rdata = mem data each time.
REQ-028 id0 LR 0x100 (set_res id0 0x100), id0 SC 0x100, gnt=1 -> write issued, o_tbl_wr_en pulse, o_rdata=0.
REQ-029 id0 LR 0x100, id1 store 0x100, id0 SC 0x100, gnt=0 -> no o_mem_en in SC, o_rdata=1, o_ack[0] one cycle.
REQ-030 Continuous i_req=2'b11 with RR enabled -> grants alternate 0,1,0,1; without macro -> id0 only.
REQ-031 i_rst asserted during MEM with i_mem_ack next cycle -> no o_ack, no o_tbl_wr_en, FSM IDLE.
